dmem_lsu: RTL and testbench

//  Load/store initiator between the CPU datapath and the word-wide data memory (dmem) port.

---
 rtl/dmem_lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/dmem_lsu.sv | 147 ++++++++++++++
 tb/tb_dmem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the load/store unit.
//  - SZ_* request size encodings (byte/half/word/illegal)
//  - lsu_state_e FSM state encoding (IDLE/RD/WR/RESP)
//  - lsu_misaligned(): alignment/size legality check applied at request accept
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // True when the request must be answered with resp_err and no memory access.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane handling for a little-endian 32-bit word.
//  size        in  2   SZ_BYTE/SZ_HALF/SZ_WORD
//  lane        in  2   byte address bits [1:0]
//  is_unsigned in  1   zero-extend (1) or sign-extend (0) load data
//  word        in  32  word read from memory
//  store_data  in  32  right-aligned store data
//  load_data   out 32  selected lane, extended to 32 bits
//  merged      out 32  word with the target lane(s) replaced by store_data
module lsu_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = word[{lane[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged[{lane, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data = word;
        merged    = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the CPU datapath and the word-wide dmem port.
//  Request side : req_valid/req_ready handshake, req_we, req_size, req_unsigned, req_addr, req_wdata
//  Response side: resp_valid (1-cycle pulse), resp_rdata (extended load data), resp_err
//  dmem side    : CS, DM_W, DM_R, addr (word aligned), wdata (merged word), rdata
//  Sub-word stores are a read-modify-write of the containing word. All dmem and response
//  outputs are registered.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        CS,
  output logic        DM_W,
  output logic        DM_R,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  localparam logic [1:0] LatInit = 2'(RD_LAT);

  lsu_state_e  state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [31:0] sdata_q;
  logic        cs_q, dm_w_q, dm_r_q, resp_valid_q, resp_err_q;
  logic [31:0] addr_q, wdata_q, resp_rdata_q;

  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_lane_align u_lane_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .word        (rdata),
    .store_data  (sdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      lane_q       <= 2'b00;
      uns_q        <= 1'b0;
      sdata_q      <= 32'h0;
      cs_q         <= 1'b0;
      dm_w_q       <= 1'b0;
      dm_r_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      cs_q         <= 1'b0;
      dm_w_q       <= 1'b0;
      dm_r_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            lane_q       <= req_addr[1:0];
            uns_q        <= req_unsigned;
            sdata_q      <= req_wdata;
            addr_q       <= {req_addr[31:2], 2'b00};
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            if (lsu_misaligned(req_size, req_addr[1:0])) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state_q <= WR;
              cs_q    <= 1'b1;
              dm_w_q  <= 1'b1;
              wdata_q <= req_wdata;
            end else begin
              state_q <= RD;
              cs_q    <= 1'b1;
              dm_r_q  <= 1'b1;
              cnt_q   <= LatInit;
            end
          end
        end
        RD: begin
          // rdata is valid in the last RD cycle and is consumed on its closing edge.
          if (cnt_q == 2'd0) begin
            if (we_q) begin
              state_q <= WR;
              cs_q    <= 1'b1;
              dm_w_q  <= 1'b1;
              wdata_q <= merged;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= load_data;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign CS         = cs_q;
  assign DM_W       = dm_w_q;
  assign DM_R       = dm_r_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (RD_LAT = 1, 2, 3), each with its own behavioural dmem.
// Requests go to the instance selected by sel; expectations are queued at drive time and
// popped when the response pulse appears.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  int          sel = 0;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        ready_a [3];
  logic        resp_valid_a [3];
  logic [31:0] resp_rdata_a [3];
  logic        resp_err_a [3];
  logic        cs_a [3];
  logic        dm_w_a [3];
  logic        dm_r_a [3];
  logic [31:0] addr_a [3];
  logic [31:0] wdata_a [3];

  logic [31:0] mem [3][16];
  logic [31:0] rd_pipe [3][3];

  int nvec = 0;
  int nerr = 0;
  int ovl = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lsu #(.RD_LAT(g + 1)) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .req_valid    (req_valid && (sel == g)),
      .req_ready    (ready_a[g]),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid_a[g]),
      .resp_rdata   (resp_rdata_a[g]),
      .resp_err     (resp_err_a[g]),
      .CS           (cs_a[g]),
      .DM_W         (dm_w_a[g]),
      .DM_R         (dm_r_a[g]),
      .addr         (addr_a[g]),
      .wdata        (wdata_a[g]),
      .rdata        (rd_pipe[g][g])
    );
  end

  // Behavioural dmem: write on the closing edge of a CS&DM_W cycle; read data appears
  // RD_LAT cycles after the CS&DM_R cycle and is garbage otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (preload) begin
        for (int w = 0; w < 16; w++) mem[k][w] <= (w == 0) ? 32'h8899AABB : 32'h0;
      end else if (cs_a[k] && dm_w_a[k]) begin
        mem[k][addr_a[k][5:2]] <= wdata_a[k];
      end
      rd_pipe[k][0] <= (cs_a[k] && dm_r_a[k]) ? mem[k][addr_a[k][5:2]] : 32'h0BAD0BAD;
      rd_pipe[k][1] <= rd_pipe[k][0];
      rd_pipe[k][2] <= rd_pipe[k][1];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (dm_r_a[k] && dm_w_a[k]) ovl <= ovl + 1;
  end

  logic        cur_ready, cur_resp_valid, cur_resp_err, cur_cs, cur_dm_w, cur_dm_r;
  logic [31:0] cur_resp_rdata, cur_addr, cur_wdata;
  assign cur_ready      = ready_a[sel];
  assign cur_resp_valid = resp_valid_a[sel];
  assign cur_resp_err   = resp_err_a[sel];
  assign cur_resp_rdata = resp_rdata_a[sel];
  assign cur_cs         = cs_a[sel];
  assign cur_dm_w       = dm_w_a[sel];
  assign cur_dm_r       = dm_r_a[sel];
  assign cur_addr       = addr_a[sel];
  assign cur_wdata      = wdata_a[sel];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ncs;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the selected instance: checked for data, error, latency, dmem strobes.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic [31:0] exp_wd, input string tag);
    exp_t e, got_e;
    logic err, word_st, rd, wr, got, busy_bad;
    int   lat_seen, ncs, nwr;
    logic [31:0] wseen, aseen;
    int   rd_lat = sel + 1;
    err     = (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    word_st = we && (size == 2'b10);
    rd      = !err && !word_st;
    wr      = !err && we;
    e.rdata = exp_rd;
    e.err   = err;
    e.lat   = err ? 1 : (!we ? rd_lat + 2 : (word_st ? 2 : rd_lat + 3));
    e.ncs   = (rd ? 1 : 0) + (wr ? 1 : 0);
    e.nwr   = wr ? 1 : 0;
    e.wdata = exp_wd;
    e.waddr = {a[31:2], 2'b00};

    @(negedge clk);
    chk({tag, " ready"}, 32'(cur_ready), 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    got = 1'b0; busy_bad = 1'b0; lat_seen = 0; ncs = 0; nwr = 0; wseen = 32'h0; aseen = 32'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (cur_cs) ncs++;
      if (cur_dm_w) begin
        nwr++;
        wseen = cur_wdata;
        aseen = cur_addr;
      end
      if (cur_ready) busy_bad = 1'b1;
      if (cur_resp_valid) begin
        got = 1'b1;
        lat_seen = n;
        break;
      end
    end
    chk({tag, " resp seen"}, 32'(got), 32'd1);
    got_e = sbq.pop_front();
    if (got) begin
      chk({tag, " latency"}, 32'(lat_seen), 32'(got_e.lat));
      chk({tag, " err"}, 32'(cur_resp_err), 32'(got_e.err));
      if (!got_e.err) chk({tag, " rdata"}, cur_resp_rdata, got_e.rdata);
    end
    chk({tag, " ready low while busy"}, 32'(busy_bad), 32'd0);
    chk({tag, " CS cycles"}, 32'(ncs), 32'(got_e.ncs));
    chk({tag, " DM_W cycles"}, 32'(nwr), 32'(got_e.nwr));
    if (got_e.nwr > 0) begin
      chk({tag, " wdata"}, wseen, got_e.wdata);
      chk({tag, " waddr"}, aseen, got_e.waddr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rv, wv;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk("reset ctl {ready,cs,dmr,dmw,rv,err}",
        32'({cur_ready, cur_cs, cur_dm_r, cur_dm_w, cur_resp_valid, cur_resp_err}), 32'b100000);
    chk("reset addr", cur_addr, 32'h0);
    chk("reset wdata", cur_wdata, 32'h0);
    chk("reset resp_rdata", cur_resp_rdata, 32'h0);
    rst_n = 1'b1;

    sel = 0;
    // Word store / load
    txn(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, "sw 0x4");
    txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 32'h0, "lw 0x4");
    // Byte store read-modify-write, upper store bits must be ignored
    txn(1'b1, 2'b00, 1'b0, 32'h1, 32'hABCDEF55, 32'h0, 32'h889955BB, "sb 0x1");
    // Lane extraction and extension
    txn(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'hFFFFFF88, 32'h0, "lb 0x3");
    txn(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'h00000088, 32'h0, "lbu 0x3");
    txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFF8899, 32'h0, "lh 0x2");
    txn(1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h000055BB, 32'h0, "lhu 0x0");
    txn(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h00000055, 32'h0, "lb 0x1");
    txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h889955BB, 32'h0, "lw 0x0");
    // Errors: no dmem access
    txn(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, "lh misaligned");
    txn(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, "size 11");
    txn(1'b1, 2'b10, 1'b0, 32'h2, 32'h12345678, 32'h0, 32'h0, "sw misaligned");
    // Half and byte stores into upper lanes
    txn(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, 32'h0, 32'h1234BEEF, "sh 0x6");
    txn(1'b1, 2'b00, 1'b0, 32'h4, 32'h00000099, 32'h0, 32'h1234BE99, "sb 0x4");
    txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234BE99, 32'h0, "lw 0x4 after rmw");

    // Reset during the RD of a byte store
    @(negedge clk);
    chk("abort ready", 32'(cur_ready), 32'd1);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h1;
    req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort RD started", 32'({cur_cs, cur_dm_r}), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort ctl {ready,cs,dmr,dmw,rv,err}",
        32'({cur_ready, cur_cs, cur_dm_r, cur_dm_w, cur_resp_valid, cur_resp_err}), 32'b100000);
    chk("abort addr", cur_addr, 32'h0);
    chk("abort wdata", cur_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0; wv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (cur_resp_valid) rv++;
      if (cur_dm_w) wv++;
    end
    chk("abort no resp", 32'(rv), 32'd0);
    chk("abort no write", 32'(wv), 32'd0);
    chk("abort word 0x0 unchanged", mem[0][0], 32'h889955BB);

    // Back-to-back stream on each read latency
    for (int k = 0; k < 3; k++) begin
      sel = k;
      txn(1'b1, 2'b10, 1'b0, 32'h8, 32'h01020304, 32'h0, 32'h01020304, $sformatf("L%0d sw", k + 1));
      txn(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA, 32'h0, 32'h0102AA04, $sformatf("L%0d sb", k + 1));
      txn(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h00000102, 32'h0, $sformatf("L%0d lh", k + 1));
      txn(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'hFFFFFFAA, 32'h0, $sformatf("L%0d lb", k + 1));
      txn(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'h0000AA04, 32'h0, $sformatf("L%0d lhu", k + 1));
      txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0102AA04, 32'h0, $sformatf("L%0d lw", k + 1));
      txn(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h000000BB, 32'h0, $sformatf("L%0d lbu", k + 1));
      txn(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 32'h0, $sformatf("L%0d lh err", k + 1));
    end

    chk("DM_R/DM_W overlap count", 32'(ovl), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
